// File: rtl/sdram_write_arbiter.sv
// Two-port SDRAM write arbiter: per-port {addr,data} FIFOs feed one registered output word.
// Latency: a word pushed into an empty FIFO while idle is presented one edge after the push edge.
// Backpressure: iSDRAM_busy holds the output word; full FIFOs drop words and set sticky ovf. Option: SDRAM_ARB_ROUND_ROBIN_EN.

module sdram_arb_fifo #(
   parameter int W          = 40,
   parameter int DEPTH_LOG2 = 2
) (
   input  logic                  iCLK,
   input  logic                  iRST,
   input  logic                  push,
   input  logic [W-1:0]          push_dat,
   input  logic                  pop,
   output logic [W-1:0]          head_dat,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  full,
   output logic                  empty
);
   localparam int D  = 1 << DEPTH_LOG2;
   localparam int LW = DEPTH_LOG2 + 1;

   logic [W-1:0]            mem [D];
   logic [DEPTH_LOG2-1:0]   wr_ptr;
   logic [DEPTH_LOG2-1:0]   rd_ptr;

   always_ff @(posedge iCLK) begin
      if (push) mem[wr_ptr] <= push_dat;
   end

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
         if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   assign head_dat = mem[rd_ptr];
   assign full     = (level == LW'(D));
   assign empty    = (level == '0);
endmodule

module sdram_write_arbiter #(
   parameter int DEPTH_LOG2 = 2
) (
   input  logic                  iCLK,
   input  logic                  iRST,
   input  logic                  iA_valid,
   input  logic [15:0]           iA_data,
   input  logic [23:0]           iA_addr,
   input  logic                  iB_valid,
   input  logic [15:0]           iB_data,
   input  logic [23:0]           iB_addr,
   input  logic                  iClr_ovf,
   input  logic                  iSDRAM_busy,
   output logic                  oSDRAM_valid,
   output logic [15:0]           oSDRAM_data,
   output logic [23:0]           oSDRAM_addr,
   output logic                  oSrc,
   output logic                  oA_ovf,
   output logic                  oB_ovf,
   output logic [DEPTH_LOG2:0]   oA_level,
   output logic [DEPTH_LOG2:0]   oB_level
);
   typedef enum logic {IDLE, SEND} state_t;

   state_t        state;
   state_t        state_nxt;
   logic          do_pop;
   logic          sel_b;
   logic          a_push, b_push, a_pop, b_pop;
   logic          a_full, b_full, a_empty, b_empty;
   logic [39:0]   a_head, b_head;

   sdram_arb_fifo #(.W(40), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo_a (
      .iCLK(iCLK), .iRST(iRST), .push(a_push), .push_dat({iA_addr, iA_data}),
      .pop(a_pop), .head_dat(a_head), .level(oA_level), .full(a_full), .empty(a_empty)
   );

   sdram_arb_fifo #(.W(40), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo_b (
      .iCLK(iCLK), .iRST(iRST), .push(b_push), .push_dat({iB_addr, iB_data}),
      .pop(b_pop), .head_dat(b_head), .level(oB_level), .full(b_full), .empty(b_empty)
   );

   // A full FIFO still accepts a word when its head leaves on the same edge.
   assign a_push = iA_valid && (!a_full || a_pop);
   assign b_push = iB_valid && (!b_full || b_pop);
   assign a_pop  = do_pop && !sel_b;
   assign b_pop  = do_pop &&  sel_b;

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
   // rr_fav_b names the port favoured on the next contended grant.
   logic rr_fav_b;

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST)       rr_fav_b <= 1'b0;
      else if (do_pop) rr_fav_b <= !sel_b;
   end

   assign sel_b = !b_empty && (a_empty || rr_fav_b);
`else
   assign sel_b = a_empty;
`endif

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      do_pop       = 1'b0;
      oSDRAM_valid = 1'b0;
      case (state)
         IDLE: begin
            if (!a_empty || !b_empty) begin
               do_pop    = 1'b1;
               state_nxt = SEND;
            end
         end
         SEND: begin
            oSDRAM_valid = 1'b1;
            if (!iSDRAM_busy) begin
               if (!a_empty || !b_empty) do_pop    = 1'b1;
               else                      state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         oSDRAM_data <= '0;
         oSDRAM_addr <= '0;
         oSrc        <= 1'b0;
      end else if (do_pop) begin
         oSDRAM_data <= sel_b ? b_head[15:0]  : a_head[15:0];
         oSDRAM_addr <= sel_b ? b_head[39:16] : a_head[39:16];
         oSrc        <= sel_b;
      end
   end

   // A new overflow beats a same-cycle clear.
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         oA_ovf <= 1'b0;
         oB_ovf <= 1'b0;
      end else begin
         if (iA_valid && a_full && !a_pop) oA_ovf <= 1'b1;
         else if (iClr_ovf)                oA_ovf <= 1'b0;
         if (iB_valid && b_full && !b_pop) oB_ovf <= 1'b1;
         else if (iClr_ovf)                oB_ovf <= 1'b0;
      end
   end
endmodule

// File: tb/tb_sdram_write_arbiter.sv
// Scoreboard bench for sdram_write_arbiter: queue-level reference model predicts grants,
// drops and levels; a negedge monitor checks every transferred word against the expected queue.
module tb_sdram_write_arbiter;
   localparam int DL2 = 2;
   localparam int D   = 1 << DL2;

   typedef struct packed {
      logic [23:0] addr;
      logic [15:0] data;
   } ent_t;

   typedef struct packed {
      logic        src;
      logic [23:0] addr;
      logic [15:0] data;
   } word_t;

   logic            iCLK = 1'b0;
   logic            iRST = 1'b0;
   logic            iA_valid = 1'b0;
   logic [15:0]     iA_data = '0;
   logic [23:0]     iA_addr = '0;
   logic            iB_valid = 1'b0;
   logic [15:0]     iB_data = '0;
   logic [23:0]     iB_addr = '0;
   logic            iClr_ovf = 1'b0;
   logic            iSDRAM_busy = 1'b0;
   logic            oSDRAM_valid;
   logic [15:0]     oSDRAM_data;
   logic [23:0]     oSDRAM_addr;
   logic            oSrc;
   logic            oA_ovf, oB_ovf;
   logic [DL2:0]    oA_level, oB_level;

   sdram_write_arbiter #(.DEPTH_LOG2(DL2)) dut (
      .iCLK(iCLK), .iRST(iRST),
      .iA_valid(iA_valid), .iA_data(iA_data), .iA_addr(iA_addr),
      .iB_valid(iB_valid), .iB_data(iB_data), .iB_addr(iB_addr),
      .iClr_ovf(iClr_ovf), .iSDRAM_busy(iSDRAM_busy),
      .oSDRAM_valid(oSDRAM_valid), .oSDRAM_data(oSDRAM_data), .oSDRAM_addr(oSDRAM_addr),
      .oSrc(oSrc), .oA_ovf(oA_ovf), .oB_ovf(oB_ovf),
      .oA_level(oA_level), .oB_level(oB_level)
   );

   always #5 iCLK = ~iCLK;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: queues per port, one output slot, last-granted port, sticky flags.
   ent_t  qa[$];
   ent_t  qb[$];
   word_t expq[$];
   bit    m_slot;
   word_t m_cur;
   bit    m_last_b;
   bit    m_ovfa, m_ovfb;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      qa.delete();
      qb.delete();
      expq.delete();
      m_slot   = 1'b0;
      m_cur    = '0;
      m_last_b = 1'b1;   // so the first contended grant goes to A
      m_ovfa   = 1'b0;
      m_ovfb   = 1'b0;
   endtask

   task automatic check_state(string tag);
      chk({tag, "_valid"},   oSDRAM_valid, m_slot);
      chk({tag, "_a_level"}, oA_level, qa.size());
      chk({tag, "_b_level"}, oB_level, qb.size());
      chk({tag, "_a_ovf"},   oA_ovf, m_ovfa);
      chk({tag, "_b_ovf"},   oB_ovf, m_ovfb);
      if (m_slot) begin
         chk({tag, "_data"}, oSDRAM_data, m_cur.data);
         chk({tag, "_addr"}, oSDRAM_addr, m_cur.addr);
         chk({tag, "_src"},  oSrc, m_cur.src);
      end
   endtask

   // Called at posedge+1: drive inputs, predict the next edge, then check after it.
   task automatic step(bit va, logic [15:0] da, logic [23:0] aa,
                       bit vb, logic [15:0] db, logic [23:0] ab,
                       bit clr, bit busy);
      bit   xfer, take_b, a_over, b_over;
      ent_t e;
      iA_valid = va; iA_data = da; iA_addr = aa;
      iB_valid = vb; iB_data = db; iB_addr = ab;
      iClr_ovf = clr; iSDRAM_busy = busy;

      xfer = m_slot && !busy;
      if (!m_slot || xfer) begin
         if (qa.size() > 0 || qb.size() > 0) begin
            if (qa.size() == 0)      take_b = 1'b1;
            else if (qb.size() == 0) take_b = 1'b0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
            else                     take_b = !m_last_b;
`else
            else                     take_b = 1'b0;
`endif
            e = take_b ? qb.pop_front() : qa.pop_front();
            m_cur    = {take_b, e.addr, e.data};
            m_slot   = 1'b1;
            m_last_b = take_b;
            expq.push_back(m_cur);
         end else begin
            m_slot = 1'b0;
         end
      end

      a_over = 1'b0;
      b_over = 1'b0;
      if (va) begin
         if (qa.size() < D) qa.push_back({aa, da});
         else               a_over = 1'b1;
      end
      if (vb) begin
         if (qb.size() < D) qb.push_back({ab, db});
         else               b_over = 1'b1;
      end
      m_ovfa = a_over ? 1'b1 : (clr ? 1'b0 : m_ovfa);
      m_ovfb = b_over ? 1'b1 : (clr ? 1'b0 : m_ovfb);

      @(posedge iCLK);
      #1;
      check_state("cyc");
   endtask

   task automatic idle(int n, bit busy);
      for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, '0, 0, busy);
   endtask

   task automatic drain();
      for (int i = 0; i < 40; i++) begin
         if (!m_slot && qa.size() == 0 && qb.size() == 0) break;
         step(0, '0, '0, 0, '0, '0, 0, 0);
      end
      idle(2, 0);
      chk("drain_expq_empty", expq.size(), 0);
   endtask

   // Monitor: a transfer happens on the next edge when valid && !busy at the falling edge.
   initial begin
      word_t w;
      forever begin
         @(negedge iCLK);
         if (iRST && oSDRAM_valid && !iSDRAM_busy) begin
            if (expq.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL xfer_unexpected: got %0h@%0h src %0b expected no word",
                        oSDRAM_data, oSDRAM_addr, oSrc);
            end else begin
               w = expq.pop_front();
               chk("xfer_data", oSDRAM_data, w.data);
               chk("xfer_addr", oSDRAM_addr, w.addr);
               chk("xfer_src",  oSrc, w.src);
            end
         end
      end
   end

   initial begin
      model_reset();
      iRST = 1'b0;
      repeat (2) @(posedge iCLK);
      #1;
      chk("rst_valid", oSDRAM_valid, 0);
      chk("rst_data",  oSDRAM_data, 0);
      chk("rst_addr",  oSDRAM_addr, 0);
      chk("rst_src",   oSrc, 0);
      chk("rst_a_level", oA_level, 0);
      chk("rst_b_level", oB_level, 0);
      chk("rst_a_ovf", oA_ovf, 0);
      chk("rst_b_ovf", oB_ovf, 0);
      @(posedge iCLK);
      #1;
      iRST = 1'b1;

      // Single A word, not busy.
      step(1, 16'hBEEF, 24'h000100, 0, '0, '0, 0, 0);
      idle(4, 0);

      // Output held while busy for 5 cycles, then one transfer.
      step(1, 16'h1234, 24'h800000, 0, '0, '0, 0, 1);
      idle(5, 1);
      idle(3, 0);

      // Overflow on A while busy, then clear; then clear racing a new overflow.
      for (int i = 0; i < 6; i++) step(1, 16'h0A00 + 16'(i), 24'h010000 + 24'(i), 0, '0, '0, 0, 1);
      chk("ovf_level_full", oA_level, D);
      step(1, 16'h0AFF, 24'h0100FF, 0, '0, '0, 1, 1);
      step(0, '0, '0, 0, '0, '0, 1, 1);
      // Full FIFO, pop and push in the same cycle.
      step(1, 16'h0B00, 24'h020000, 0, '0, '0, 0, 0);
      chk("full_push_pop_level", oA_level, D);
      drain();

      // Both ports, three words each.
      for (int i = 0; i < 3; i++)
         step(1, 16'hA000 + 16'(i), 24'h100000 + 24'(i), 1, 16'hB000 + 16'(i), 24'h200000 + 24'(i), 0, 0);
      drain();

      // B full overflow with B-only traffic.
      for (int i = 0; i < 7; i++) step(0, '0, '0, 1, 16'hC000 + 16'(i), 24'h300000 + 24'(i), 0, 1);
      step(0, '0, '0, 0, '0, '0, 1, 0);
      drain();

      // Reset mid-SEND with words queued.
      for (int i = 0; i < 4; i++) step(1, 16'hD000 + 16'(i), 24'h400000 + 24'(i), 0, '0, '0, 0, 1);
      iRST = 1'b0;
      iA_valid = 1'b0; iB_valid = 1'b0; iClr_ovf = 1'b0; iSDRAM_busy = 1'b0;
      model_reset();
      #1;
      chk("midrst_valid", oSDRAM_valid, 0);
      chk("midrst_a_level", oA_level, 0);
      chk("midrst_b_level", oB_level, 0);
      @(posedge iCLK);
      #1;
      iRST = 1'b1;
      idle(6, 0);

      // Randomized traffic in phases of varying congestion.
      for (int ph = 0; ph < 4; ph++) begin
         int pa, pb, pbusy;
         pa    = 20 + ph * 20;
         pb    = 70 - ph * 15;
         pbusy = 10 + ph * 20;
         for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < pa, 16'($urandom), 24'($urandom),
                 $urandom_range(0, 99) < pb, 16'($urandom), 24'($urandom),
                 $urandom_range(0, 99) < 5, $urandom_range(0, 99) < pbusy);
         end
         drain();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
